gshare_pred_queue: RTL and testbench

Parametrised successor to the single-shot gshare datapath. It accepts one prediction request per cycle and keeps up to QDEPTH unresolved predictions in an in-order queue. Resolutions retire the queue head in order. Global history is updated speculatively and is repaired on a mispredict, which also flushes the queue. It sits between fetch (predict side) and branch execute (resolve side).

---
 rtl/gshare_pred_queue.sv | 168 ++++++++++++++++
 tb/tb_gshare_pred_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pred_queue.sv
// Pipelined gshare predictor with an in-order queue of unresolved predictions.
// Optional counters enabled by GSHARE_PRED_STATS_EN (stat_retired, stat_mispred).
module gshare_pred_queue #(
    parameter int W      = 32,
    parameter int HIST   = 8,
    parameter int L_BTB  = 16,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pred_req,
    input  logic [W-1:0]              pred_pc,
    output logic                      pred_ready,
    output logic                      pred_valid,
    output logic                      pred_taken,
    output logic [W-1:0]              pred_target,
    input  logic                      res_valid,
    input  logic                      res_taken,
    input  logic [W-1:0]              res_target,
    output logic                      res_ready,
    output logic                      mispredict,
`ifdef GSHARE_PRED_STATS_EN
    output logic [31:0]               stat_retired,
    output logic [31:0]               stat_mispred,
`endif
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int PHT_N = 1 << HIST;
    localparam int LB    = $clog2(L_BTB);
    localparam int TW    = W - LB - 2;
    localparam int QW    = $clog2(QDEPTH);
    localparam int CW    = QW + 1;

    logic [1:0]      pht_q [PHT_N];
    logic [L_BTB-1:0] btb_vld_q;
    logic [TW-1:0]   btb_tag_q [L_BTB];
    logic [W-1:0]    btb_tgt_q [L_BTB];
    logic [HIST-1:0] ghr_q, ghr_d;

    logic [LB-1:0]   q_set_q [QDEPTH];
    logic [TW-1:0]   q_tag_q [QDEPTH];
    logic [HIST-1:0] q_idx_q [QDEPTH];
    logic [HIST-1:0] q_ghr_q [QDEPTH];
    logic [W-1:0]    q_tgt_q [QDEPTH];
    logic [QDEPTH-1:0] q_tkn_q;
    logic [QW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;

    logic            pred_valid_q, pred_taken_q, mispred_q;
    logic [W-1:0]    pred_target_q;

    logic [HIST-1:0] lk_idx;
    logic [LB-1:0]   lk_set;
    logic [TW-1:0]   lk_tag;
    logic            lk_taken;
    logic [W-1:0]    lk_target;
    logic            accept, retire, hd_mis, flush;
    logic [LB-1:0]   hd_set;
    logic [HIST-1:0] hd_idx;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    always_comb begin
        lk_idx    = pred_pc[HIST+1:2] ^ ghr_q;
        lk_set    = pred_pc[LB+1:2];
        lk_tag    = pred_pc[W-1:LB+2];
        lk_taken  = pht_q[lk_idx][1] & btb_vld_q[lk_set] & (btb_tag_q[lk_set] == lk_tag);
        lk_target = lk_taken ? btb_tgt_q[lk_set] : pred_pc + W'(4);

        pred_ready = (count_q != CW'(QDEPTH));
        res_ready  = (count_q != '0);
        accept     = pred_req & pred_ready;
        retire     = res_valid & res_ready;

        hd_set = q_set_q[head_q];
        hd_idx = q_idx_q[head_q];
        hd_mis = (res_taken != q_tkn_q[head_q]) |
                 (res_taken & q_tkn_q[head_q] & (res_target != q_tgt_q[head_q]));
        flush  = retire & hd_mis;

        // Repair outranks the speculative shift of a same-cycle accept.
        ghr_d = ghr_q;
        if (flush)       ghr_d = {q_ghr_q[head_q][HIST-2:0], res_taken};
        else if (accept) ghr_d = {ghr_q[HIST-2:0], lk_taken};

        count_d = count_q;
        if (flush) count_d = '0;
        else       count_d = count_q + CW'(accept) - CW'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
            btb_vld_q     <= '0;
            ghr_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            mispred_q     <= 1'b0;
        end else begin
            ghr_q        <= ghr_d;
            count_q      <= count_d;
            pred_valid_q <= accept & ~flush;
            mispred_q    <= flush;
            if (accept & ~flush) begin
                pred_taken_q  <= lk_taken;
                pred_target_q <= lk_target;
            end
            if (retire) begin
                pht_q[hd_idx] <= sat2(pht_q[hd_idx], res_taken);
                if (res_taken) begin
                    btb_vld_q[hd_set] <= 1'b1;
                    btb_tag_q[hd_set] <= q_tag_q[head_q];
                    btb_tgt_q[hd_set] <= res_target;
                end
            end
            if (flush) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (retire) head_q <= head_q + QW'(1);
                if (accept) tail_q <= tail_q + QW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_set_q[tail_q] <= lk_set;
            q_tag_q[tail_q] <= lk_tag;
            q_idx_q[tail_q] <= lk_idx;
            q_ghr_q[tail_q] <= ghr_q;
            q_tkn_q[tail_q] <= lk_taken;
            q_tgt_q[tail_q] <= lk_target;
        end
    end

`ifdef GSHARE_PRED_STATS_EN
    logic [31:0] stat_ret_q, stat_mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ret_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (retire && stat_ret_q != '1) stat_ret_q <= stat_ret_q + 32'd1;
            if (flush  && stat_mis_q != '1) stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_retired = stat_ret_q;
    assign stat_mispred = stat_mis_q;
`endif

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign mispredict  = mispred_q;
    assign q_count     = count_q;

endmodule

// File: tb/tb_gshare_pred_queue.sv
// Directed self-checking bench for gshare_pred_queue (default parameters).
module tb_gshare_pred_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_ready, pred_valid, pred_taken;
    logic [31:0] pred_target;
    logic        res_valid, res_taken;
    logic [31:0] res_target;
    logic        res_ready, mispredict;
    logic [2:0]  q_count;
`ifdef GSHARE_PRED_STATS_EN
    logic [31:0] stat_retired, stat_mispred;
`endif

    int n_pass  = 0;
    int n_total = 0;

    gshare_pred_queue dut (
        .clk         (clk),
        .rst         (rst),
        .pred_req    (pred_req),
        .pred_pc     (pred_pc),
        .pred_ready  (pred_ready),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .res_ready   (res_ready),
        .mispredict  (mispredict),
`ifdef GSHARE_PRED_STATS_EN
        .stat_retired(stat_retired),
        .stat_mispred(stat_mispred),
`endif
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [2:0]  exp_count;
        logic        exp_ready;
    } vec_t;

    vec_t fill_tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pred_req = 1'b0; pred_pc = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic predict(input logic [31:0] pc);
        pred_req = 1'b1; pred_pc = pc;
        cycle();
        pred_req = 1'b0;
    endtask

    task automatic resolve(input logic t, input logic [31:0] tgt);
        res_valid = 1'b1; res_taken = t; res_target = tgt;
        cycle();
        res_valid = 1'b0;
    endtask

    initial begin
        fill_tbl[0] = '{32'h100, 1'b0, 32'h104, 3'd1, 1'b1};
        fill_tbl[1] = '{32'h104, 1'b0, 32'h108, 3'd2, 1'b1};
        fill_tbl[2] = '{32'h108, 1'b0, 32'h10C, 3'd3, 1'b1};
        fill_tbl[3] = '{32'h10C, 1'b0, 32'h110, 3'd4, 1'b0};

        do_reset();
        check("rst_pred_valid", 32'(pred_valid), 32'd0);
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_pred_target", pred_target, 32'd0);
        check("rst_mispredict", 32'(mispredict), 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
        check("rst_pred_ready", 32'(pred_ready), 32'd1);
        check("rst_res_ready", 32'(res_ready), 32'd0);

        // First prediction after reset, then the PC wrap-around case.
        predict(32'h100);
        check("first_valid", 32'(pred_valid), 32'd1);
        check("first_taken", 32'(pred_taken), 32'd0);
        check("first_target", pred_target, 32'h104);
        check("first_count", 32'(q_count), 32'd1);
        resolve(1'b0, 32'h0);
        check("first_res_mis", 32'(mispredict), 32'd0);
        check("first_res_count", 32'(q_count), 32'd0);
        check("first_res_pvalid", 32'(pred_valid), 32'd0);
        predict(32'hFFFF_FFFC);
        check("wrap_target", pred_target, 32'h0);
        resolve(1'b0, 32'h0);

        // Queue fill and backpressure.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            predict(fill_tbl[i].pc);
            check($sformatf("fill%0d_valid", i), 32'(pred_valid), 32'd1);
            check($sformatf("fill%0d_taken", i), 32'(pred_taken), 32'(fill_tbl[i].exp_taken));
            check($sformatf("fill%0d_target", i), pred_target, fill_tbl[i].exp_target);
            check($sformatf("fill%0d_count", i), 32'(q_count), 32'(fill_tbl[i].exp_count));
            check($sformatf("fill%0d_ready", i), 32'(pred_ready), 32'(fill_tbl[i].exp_ready));
        end
        predict(32'h110);
        check("full_blocked_valid", 32'(pred_valid), 32'd0);
        check("full_blocked_count", 32'(q_count), 32'd4);
        // Full queue with a same-cycle retire: no bypass.
        pred_req = 1'b1; pred_pc = 32'h110;
        resolve(1'b0, 32'h0);
        pred_req = 1'b0;
        check("full_retire_valid", 32'(pred_valid), 32'd0);
        check("full_retire_count", 32'(q_count), 32'd3);
        check("full_retire_ready", 32'(pred_ready), 32'd1);
        check("full_retire_mis", 32'(mispredict), 32'd0);
        // Accept with a correct retire: count unchanged.
        pred_req = 1'b1; pred_pc = 32'h110;
        resolve(1'b0, 32'h0);
        pred_req = 1'b0;
        check("acc_ret_valid", 32'(pred_valid), 32'd1);
        check("acc_ret_target", pred_target, 32'h114);
        check("acc_ret_count", 32'(q_count), 32'd3);
        for (int i = 0; i < 3; i++) resolve(1'b0, 32'h0);
        check("drain_count", 32'(q_count), 32'd0);
        check("drain_res_ready", 32'(res_ready), 32'd0);
        resolve(1'b1, 32'h999);
        check("empty_res_mis", 32'(mispredict), 32'd0);
        check("empty_res_count", 32'(q_count), 32'd0);

        // Mispredict flush and training.
        do_reset();
        predict(32'h200);
        predict(32'h204);
        predict(32'h208);
        check("flush_pre_count", 32'(q_count), 32'd3);
        resolve(1'b1, 32'h300);
        check("flush_mis", 32'(mispredict), 32'd1);
        check("flush_count", 32'(q_count), 32'd0);
        check("flush_ghr", 32'(dut.ghr_q), 32'h01);
        check("flush_pht80", 32'(dut.pht_q[128]), 32'd2);
        check("flush_btb_vld", 32'(dut.btb_vld_q[0]), 32'd1);
        check("flush_btb_tgt", dut.btb_tgt_q[0], 32'h300);
        cycle();
        check("flush_pulse_end", 32'(mispredict), 32'd0);

        // BTB-miss gating from the post-flush state.
        predict(32'h204);
        check("miss_taken", 32'(pred_taken), 32'd0);
        check("miss_target", pred_target, 32'h208);
        resolve(1'b0, 32'h0);
        check("miss_mis", 32'(mispredict), 32'd0);
        check("miss_pht80", 32'(dut.pht_q[128]), 32'd1);
        check("miss_ghr", 32'(dut.ghr_q), 32'h02);
`ifdef GSHARE_PRED_STATS_EN
        check("stat_retired", stat_retired, 32'd2);
        check("stat_mispred", stat_mispred, 32'd1);
        do_reset();
        check("stat_retired_rst", stat_retired, 32'd0);
        check("stat_mispred_rst", stat_mispred, 32'd0);
`endif

        // Taken prediction from a trained entry, then a target mismatch.
        do_reset();
        predict(32'h200);
        resolve(1'b1, 32'h300);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) predict(32'h1004);
            for (int i = 0; i < 4; i++) resolve(1'b0, 32'h0);
        end
        check("shift_ghr_zero", 32'(dut.ghr_q), 32'h00);
        predict(32'h200);
        check("hit_taken", 32'(pred_taken), 32'd1);
        check("hit_target", pred_target, 32'h300);
        check("hit_ghr", 32'(dut.ghr_q), 32'h01);
        resolve(1'b1, 32'h340);
        check("tgt_mis", 32'(mispredict), 32'd1);
        check("tgt_mis_ghr", 32'(dut.ghr_q), 32'h01);
        check("tgt_mis_pht80", 32'(dut.pht_q[128]), 32'd3);
        check("tgt_mis_btb", dut.btb_tgt_q[0], 32'h340);

        // Reset mid-operation, then accept alongside a mispredicting retire.
        predict(32'h100);
        predict(32'h104);
        do_reset();
        check("midrst_count", 32'(q_count), 32'd0);
        check("midrst_valid", 32'(pred_valid), 32'd0);
        predict(32'h200);
        pred_req = 1'b1; pred_pc = 32'h400;
        resolve(1'b1, 32'h300);
        pred_req = 1'b0;
        check("simul_valid", 32'(pred_valid), 32'd0);
        check("simul_count", 32'(q_count), 32'd0);
        check("simul_mis", 32'(mispredict), 32'd1);
        check("simul_ghr", 32'(dut.ghr_q), 32'h01);
        cycle();
        check("simul_pulse_end", 32'(mispredict), 32'd0);
        check("simul_res_ready", 32'(res_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
